mac_host: RTL and testbench

Host-side serial initiator for the `mac_fpga` multiply-accumulate target. It accepts CLEAR, MAC and READ requests on a parallel request interface and turns each one into the `cmd[1:0]`, `clk` and `din` sequence the target expects. For READ it also shifts the target's 32-bit accumulator back in on `dout`. It sits in the host FPGA and drives the target's pins directly.

---
 rtl/mac_host.sv | 178 +++++++++++++++++
 tb/tb_mac_host.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_host.sv
// Serial host initiator for the mac_fpga multiply-accumulate target.
// Turns CLEAR/MAC/READ requests into cmd/clk/din sequences and captures READ data from dout.
module mac_host #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           mac_cmd,
    output logic                 mac_clk,
    output logic                 mac_din,
    input  logic                 mac_dout
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned NW = $clog2(2 * WIDTH + 1);
    localparam int unsigned DW = 2 * WIDTH;

    localparam logic [PW-1:0] PhaseLast = PW'(CLK_DIV - 1);
    localparam logic [NW-1:0] LastMac   = NW'(2 * WIDTH);
    localparam logic [NW-1:0] LastRead  = NW'(2 * WIDTH - 1);

    localparam logic [1:0] OpClear = 2'b00;
    localparam logic [1:0] OpMac   = 2'b01;
    localparam logic [1:0] OpRead  = 2'b10;
    localparam logic [1:0] OpRsvd  = 2'b11;

    localparam logic [1:0] CmdClear  = 2'b00;
    localparam logic [1:0] CmdShift  = 2'b01;
    localparam logic [1:0] CmdLoad   = 2'b10;
    localparam logic [1:0] CmdRotate = 2'b11;

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StFinish} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [NW-1:0]   period_q, period_d;
    logic [NW-1:0]   last_q, last_d;
    logic [1:0]      op_q, op_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW-1:0]   cap_q, cap_d;
    logic [DW-1:0]   result_q, result_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            clk_q, clk_d;
    logic            din_q, din_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            period_q <= '0;
            last_q   <= '0;
            op_q     <= OpClear;
            data_q   <= '0;
            cap_q    <= '0;
            result_q <= '0;
            cmd_q    <= CmdShift;
            clk_q    <= 1'b0;
            din_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            last_q   <= last_d;
            op_q     <= op_d;
            data_q   <= data_d;
            cap_q    <= cap_d;
            result_q <= result_d;
            cmd_q    <= cmd_d;
            clk_q    <= clk_d;
            din_q    <= din_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        period_d = period_q;
        last_d   = last_q;
        op_d     = op_q;
        data_d   = data_q;
        cap_d    = cap_q;
        result_d = result_q;
        cmd_d    = cmd_q;
        clk_d    = clk_q;
        din_d    = din_q;

        case (state_q)
            StIdle: begin
                if (req && op != OpRsvd) begin
                    state_d  = StLow;
                    phase_d  = '0;
                    period_d = '0;
                    op_d     = op;
                    case (op)
                        OpClear: begin
                            cmd_d  = CmdClear;
                            data_d = '0;
                            din_d  = 1'b0;
                            last_d = '0;
                        end
                        OpMac: begin
                            // B goes out first so it finishes in the target's B register.
                            cmd_d  = CmdShift;
                            data_d = {a_in, b_in};
                            din_d  = b_in[0];
                            last_d = LastMac;
                        end
                        default: begin
                            cmd_d  = CmdRotate;
                            data_d = '0;
                            din_d  = 1'b0;
                            last_d = LastRead;
                        end
                    endcase
                end
            end
            StLow: begin
                if (phase_q == PhaseLast) begin
                    phase_d = '0;
                    state_d = StHigh;
                    clk_d   = 1'b1;
                    if (op_q == OpRead) begin
                        cap_d = {cap_q[DW-2:0], mac_dout};
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StHigh: begin
                if (phase_q == PhaseLast) begin
                    phase_d = '0;
                    clk_d   = 1'b0;
                    data_d  = data_q >> 1;
                    if (period_q == last_q) begin
                        state_d = StFinish;
                        cmd_d   = CmdShift;
                        din_d   = 1'b0;
                        if (op_q == OpRead) begin
                            result_d = cap_q;
                        end
                    end else begin
                        state_d  = StLow;
                        period_d = period_q + 1'b1;
                        // Bit 1 is the next operand bit; it is already zero for the load period.
                        din_d    = data_q[1];
                        if (op_q == OpMac && period_q == LastRead) begin
                            cmd_d = CmdLoad;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q == StLow) || (state_q == StHigh);
    assign done    = (state_q == StFinish);
    assign result  = result_q;
    assign mac_cmd = cmd_q;
    assign mac_clk = clk_q;
    assign mac_din = din_q;

endmodule

// File: tb/tb_mac_host.sv
// Bench for mac_host: a pin-level target model answers dout, while expected accumulator
// values come from plain arithmetic on the requested operations.
module tb_mac_host;

    localparam int W  = 16;
    localparam int CD = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           req = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic [1:0]     mac_cmd;
    logic           mac_clk;
    logic           mac_din;
    logic           mac_dout;

    int checks = 0;
    int failures = 0;

    mac_host #(.WIDTH(W), .CLK_DIV(CD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mac_cmd  (mac_cmd),
        .mac_clk  (mac_clk),
        .mac_din  (mac_din),
        .mac_dout (mac_dout)
    );

    always #5 clk = ~clk;

    // Target emulation and pin monitor
    logic [W-1:0]   t_a = '0;
    logic [W-1:0]   t_b = '0;
    logic [2*W-1:0] t_acc = '0;
    logic           mclk_prev = 1'b0;
    logic [1:0]     pcmd = 2'b01;
    logic           pdin = 1'b0;
    int             rise_cnt[4] = '{0, 0, 0, 0};
    int             viol = 0;
    bit             din_log[$];

    assign mac_dout = t_acc[2*W-1];

    always @(negedge clk) begin
        if (mac_cmd == 2'b00) begin
            t_a = '0;
            t_b = '0;
            t_acc = '0;
        end
        if (mac_clk && !mclk_prev) begin
            rise_cnt[mac_cmd] = rise_cnt[mac_cmd] + 1;
            case (mac_cmd)
                2'b01: begin
                    din_log.push_back(mac_din);
                    t_b = {t_a[0], t_b[W-1:1]};
                    t_a = {mac_din, t_a[W-1:1]};
                end
                2'b10: t_acc = t_acc + (2*W)'(t_a) * (2*W)'(t_b);
                2'b11: t_acc = {t_acc[2*W-2:0], t_acc[2*W-1]};
                default: ;
            endcase
        end
        if (mac_clk && mclk_prev && (mac_cmd !== pcmd || mac_din !== pdin)) viol = viol + 1;
        mclk_prev = mac_clk;
        pcmd = mac_cmd;
        pdin = mac_din;
    end

    logic [2*W-1:0] exp_acc = '0;

    function automatic int total_rises();
        return rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
        int n;
        n = (o == 2'b00) ? 1 : (o == 2'b01) ? 2 * W + 1 : 2 * W;
        return 2 * n * CD + 1;
    endfunction

    // Issues one request in the cycle after the caller's current cycle and waits for done.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, output int lat, output bit busy1, output bit idle_ok);
        @(posedge clk); #1;
        req = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        busy1 = busy;
        while (!done && lat < 3000) begin
            if (poke && lat >= 20 && lat < 23) begin
                req = 1'b1;
                op = 2'b10;
            end else begin
                req = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        req = 1'b0;
        idle_ok = done && !busy && !mac_clk && mac_cmd == 2'b01 && !mac_din;
        if (done) begin
            case (o)
                2'b00: exp_acc = '0;
                2'b01: exp_acc = exp_acc + (2*W)'(a) * (2*W)'(b);
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        int r0;
        reset_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, result, mac_clk, mac_cmd, mac_din} !== {2'b00, 32'h0, 1'b0, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got busy=%b done=%b result=%h clk=%b cmd=%b din=%b",
                     busy, done, result, mac_clk, mac_cmd, mac_din);
        end
        r0 = total_rises();
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (total_rises() != r0 || mac_clk !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_quiet: got rises=%0d clk=%b busy=%b expected 0 0 0",
                     total_rises() - r0, mac_clk, busy);
        end
    endtask

    task automatic test_clear_read();
        int lat, c0, t0;
        bit b1, idle;
        c0 = rise_cnt[0]; t0 = total_rises();
        do_op(2'b00, '0, '0, 1'b0, lat, b1, idle);
        checks++;
        if (lat != exp_lat(2'b00) || !b1 || !idle) begin
            failures++;
            $display("FAIL clear_timing: got lat=%0d busy1=%b idle=%b expected %0d 1 1",
                     lat, b1, idle, exp_lat(2'b00));
        end
        checks++;
        if (rise_cnt[0] - c0 != 1 || total_rises() - t0 != 1) begin
            failures++;
            $display("FAIL clear_rises: got cmd00=%0d total=%0d expected 1 1",
                     rise_cnt[0] - c0, total_rises() - t0);
        end
        c0 = rise_cnt[3]; t0 = total_rises();
        do_op(2'b10, '0, '0, 1'b0, lat, b1, idle);
        checks++;
        if (lat != 257 || !b1 || !idle) begin
            failures++;
            $display("FAIL read_timing: got lat=%0d busy1=%b idle=%b expected 257 1 1", lat, b1, idle);
        end
        checks++;
        if (rise_cnt[3] - c0 != 32 || total_rises() - t0 != 32) begin
            failures++;
            $display("FAIL read_rises: got cmd11=%0d total=%0d expected 32 32",
                     rise_cnt[3] - c0, total_rises() - t0);
        end
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL read_zero: got %h expected 00000000", result);
        end
    endtask

    task automatic test_mac_small();
        int lat, s0, c1, c2, errs;
        bit b1, idle;
        logic [2*W-1:0] bits;
        do_op(2'b00, '0, '0, 1'b0, lat, b1, idle);
        s0 = din_log.size(); c1 = rise_cnt[1]; c2 = rise_cnt[2];
        do_op(2'b01, 16'd3, 16'd5, 1'b0, lat, b1, idle);
        checks++;
        if (lat != 265 || !idle) begin
            failures++;
            $display("FAIL mac_timing: got lat=%0d idle=%b expected 265 1", lat, idle);
        end
        checks++;
        if (rise_cnt[1] - c1 != 32 || rise_cnt[2] - c2 != 1) begin
            failures++;
            $display("FAIL mac_rises: got shift=%0d load=%0d expected 32 1",
                     rise_cnt[1] - c1, rise_cnt[2] - c2);
        end
        bits = {16'd3, 16'd5};
        errs = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (s0 + i >= din_log.size() || din_log[s0 + i] != bits[i]) errs++;
        end
        checks++;
        if (errs != 0 || din_log.size() - s0 != 2 * W) begin
            failures++;
            $display("FAIL mac_din_order: got %0d bit errors, %0d bits expected 0 errors 32 bits",
                     errs, din_log.size() - s0);
        end
        do_op(2'b10, '0, '0, 1'b0, lat, b1, idle);
        checks++;
        if (result !== 32'h0000000F) begin
            failures++;
            $display("FAIL mac_3x5: got %h expected 0000000f", result);
        end
    endtask

    task automatic test_wrap();
        int lat;
        bit b1, idle;
        do_op(2'b00, '0, '0, 1'b0, lat, b1, idle);
        do_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b0, lat, b1, idle);
        do_op(2'b01, 16'd2, 16'd3, 1'b0, lat, b1, idle);
        do_op(2'b10, '0, '0, 1'b0, lat, b1, idle);
        checks++;
        if (result !== 32'hFFFE0007) begin
            failures++;
            $display("FAIL mac_accumulate: got %h expected fffe0007", result);
        end
    endtask

    task automatic test_nondestructive();
        int lat;
        bit b1, idle;
        do_op(2'b00, '0, '0, 1'b0, lat, b1, idle);
        do_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b0, lat, b1, idle);
        do_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b0, lat, b1, idle);
        for (int k = 0; k < 2; k++) begin
            do_op(2'b10, '0, '0, 1'b0, lat, b1, idle);
            checks++;
            if (result !== 32'hFFFC0002) begin
                failures++;
                $display("FAIL read_repeat%0d: got %h expected fffc0002", k, result);
            end
        end
    endtask

    task automatic test_random();
        int lat, n;
        bit b1, idle;
        for (int it = 0; it < 4; it++) begin
            do_op(2'b00, '0, '0, 1'b0, lat, b1, idle);
            n = $urandom_range(3, 1);
            for (int k = 0; k < n; k++) begin
                do_op(2'b01, W'($urandom), W'($urandom), 1'b0, lat, b1, idle);
            end
            do_op(2'b10, '0, '0, 1'b0, lat, b1, idle);
            checks++;
            if (result !== exp_acc) begin
                failures++;
                $display("FAIL random_%0d: got %h expected %h", it, result, exp_acc);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, t0;
        bit b1, idle, seen;
        t0 = total_rises();
        do_op(2'b01, 16'h1234, 16'h0042, 1'b1, lat, b1, idle);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | busy | done;
        end
        checks++;
        if (lat != 265 || total_rises() - t0 != 33 || seen) begin
            failures++;
            $display("FAIL busy_ignore: got lat=%0d rises=%0d after=%b expected 265 33 0",
                     lat, total_rises() - t0, seen);
        end
        do_op(2'b10, '0, '0, 1'b0, lat, b1, idle);
        checks++;
        if (result !== exp_acc) begin
            failures++;
            $display("FAIL busy_ignore_acc: got %h expected %h", result, exp_acc);
        end
    endtask

    task automatic test_reserved();
        int t0;
        bit seen;
        t0 = total_rises();
        @(posedge clk); #1;
        req = 1'b1; op = 2'b11;
        @(posedge clk); #1;
        req = 1'b0;
        seen = busy | done;
        repeat (12) begin
            @(posedge clk); #1;
            seen = seen | busy | done;
        end
        checks++;
        if (seen || total_rises() != t0) begin
            failures++;
            $display("FAIL reserved_op: got activity=%b rises=%0d expected 0 0",
                     seen, total_rises() - t0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit b1, idle;
        do_op(2'b01, 16'h0007, 16'h0009, 1'b0, lat, b1, idle);
        do_op(2'b10, '0, '0, 1'b0, lat, b1, idle);
        checks++;
        if (!b1 || lat != 257 || result !== exp_acc) begin
            failures++;
            $display("FAIL back_to_back: got busy1=%b lat=%0d result=%h expected 1 257 %h",
                     b1, lat, result, exp_acc);
        end
    endtask

    task automatic test_reset_mid();
        int base, n, lat;
        bit b1, idle;
        base = rise_cnt[1];
        @(posedge clk); #1;
        req = 1'b1; op = 2'b01; a_in = W'($urandom); b_in = W'($urandom);
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (rise_cnt[1] - base < 10 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (n >= 400 || busy !== 1'b0 || mac_clk !== 1'b0 || mac_cmd !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b clk=%b cmd=%b wait=%0d expected 0 0 01",
                     busy, mac_clk, mac_cmd, n);
        end
        @(negedge clk) reset_n = 1'b1;
        do_op(2'b00, '0, '0, 1'b0, lat, b1, idle);
        do_op(2'b01, 16'h00FF, 16'h0101, 1'b0, lat, b1, idle);
        do_op(2'b10, '0, '0, 1'b0, lat, b1, idle);
        checks++;
        if (result !== exp_acc) begin
            failures++;
            $display("FAIL reset_recover: got %h expected %h", result, exp_acc);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL pin_stability: got %0d changes while mac_clk high expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_clear_read();
        test_mac_small();
        test_wrap();
        test_nondestructive();
        test_random();
        test_busy_ignore();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
